csa_tree_pipe: RTL and testbench

- Parametrised, pipelined carry-save reduction tree for the multiplier datapath.
- Reduces N partial products of width W to a redundant sum/carry pair.
- Also produces the resolved sum modulo 2^W.
- Adds pipeline registers every REG_EVERY compressor levels, a valid/ready handshake with global stall, and a sideband tag. The 116-bit/58-partial double-precision multiplier configuration is the default.

---
 rtl/csa_tree_pipe.sv | 169 ++++++++++++++++
 tb/tb_csa_tree_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree for the multiplier datapath.
//
// Reduces N partial products of width W to a redundant (s, t) pair using a
// balanced tree of 4:2 compressors. Each 4:2 node is two 3:2 rows. The
// resolved sum (s + t) mod 2^W is also provided. Pipeline registers follow
// every REG_EVERY compressor levels and always follow the last level, so the
// latency is ceil(LEVELS / REG_EVERY) cycles. All stages advance together
// under a single global stall.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand set present
//   in_ready     operand set accepted this cycle (equals the global advance)
//   in_partials  partial i at bits [i*W +: W]
//   in_tag       sideband tag, returned unchanged with the result
//   out_valid    result present
//   out_ready    consumer accepts the result
//   out_s        carry-save sum word
//   out_t        carry-save carry word (bit 0 always 0)
//   out_sum      (out_s + out_t) mod 2^W
//   out_tag      tag of the operand set that produced this result
module csa_tree_pipe #(
  parameter int unsigned W         = 116,
  parameter int unsigned N         = 58,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_partials,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_s,
  output logic [W-1:0]       out_t,
  output logic [W-1:0]       out_sum,
  output logic [TAG_W-1:0]   out_tag
);

  // Tree is padded to a power of two with at least one full 4:2 node.
  localparam int unsigned NP     = (N <= 4) ? 4 : (1 << $clog2(N));
  localparam int unsigned LEVELS = $clog2(NP) - 1;

  // 3:2 row, returns {carry << 1, sum}; carry out of bit W-1 is dropped.
  function automatic logic [2*W-1:0] csa32(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    logic [W-1:0] s;
    logic [W-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  // 4:2 node, returns {t, s}.
  function automatic logic [2*W-1:0] csa42(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c,
                                           input logic [W-1:0] d);
    logic [2*W-1:0] r1;
    r1 = csa32(a, b, c);
    return csa32(r1[W-1:0], r1[2*W-1:W], d);
  endfunction

  logic adv;

  always_comb begin
    adv = !out_valid || out_ready;
  end

  logic [NP*W-1:0] partials_pad;

  always_comb begin
    partials_pad          = '0;
    partials_pad[N*W-1:0] = in_partials;
  end

  // Level l consumes 4 words per node and emits 2 (s at even, t at odd word),
  // so node j of level l merges subtrees 2j (a, b) and 2j+1 (c, d).
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NodesL = NP >> (l + 1);
    localparam bit          IsReg  = ((l % REG_EVERY) == 0) || (l == LEVELS);

    logic [4*NodesL*W-1:0] din;
    logic                  vin;
    logic [TAG_W-1:0]      tin;
    logic [2*NodesL*W-1:0] cmp;
    logic [2*NodesL*W-1:0] dout;
    logic                  vout;
    logic [TAG_W-1:0]      tout;

    if (l == 1) begin : g_src
      always_comb begin
        din = partials_pad;
        vin = in_valid;
        tin = in_tag;
      end
    end else begin : g_src
      always_comb begin
        din = g_lvl[l-1].dout;
        vin = g_lvl[l-1].vout;
        tin = g_lvl[l-1].tout;
      end
    end

    always_comb begin
      cmp = '0;
      for (int unsigned j = 0; j < NodesL; j++) begin
        cmp[2*j*W +: 2*W] = csa42(din[(4*j)*W +: W],   din[(4*j+1)*W +: W],
                                  din[(4*j+2)*W +: W], din[(4*j+3)*W +: W]);
      end
    end

    if (IsReg) begin : g_reg
      logic                  vld_d, vld_q;
      logic [2*NodesL*W-1:0] dat_d, dat_q;
      logic [TAG_W-1:0]      tag_d, tag_q;

      // Invalid slots still load data; only valid-qualified contents matter.
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        tag_d = tag_q;
        if (adv) begin
          vld_d = vin;
          dat_d = cmp;
          tag_d = tin;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          dat_q <= '0;
          tag_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
          tag_q <= tag_d;
        end
      end

      always_comb begin
        vout = vld_q;
        dout = dat_q;
        tout = tag_q;
      end
    end else begin : g_comb
      always_comb begin
        vout = vin;
        dout = cmp;
        tout = tin;
      end
    end
  end

  always_comb begin
    in_ready  = adv;
    out_valid = g_lvl[LEVELS].vout;
    out_s     = g_lvl[LEVELS].dout[W-1:0];
    out_t     = g_lvl[LEVELS].dout[2*W-1:W];
    out_tag   = g_lvl[LEVELS].tout;
    out_sum   = out_s + out_t;
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
module tb_csa_tree_pipe;

  localparam int unsigned DW   = 116;
  localparam int unsigned DN   = 58;
  localparam int unsigned DLAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Small config: W=8, N=5, REG_EVERY=1 -> NP=8, LAT=2
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [39:0] s_in_partials;
  logic [3:0]  s_in_tag, s_out_tag;
  logic [7:0]  s_out_s, s_out_t, s_out_sum;

  csa_tree_pipe #(.W(8), .N(5), .REG_EVERY(1), .TAG_W(4)) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_partials(s_in_partials),
    .in_tag     (s_in_tag),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_s      (s_out_s),
    .out_t      (s_out_t),
    .out_sum    (s_out_sum),
    .out_tag    (s_out_tag)
  );

  // N=2 config: NP=4, LEVELS=1, LAT=1
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [15:0] n_in_partials;
  logic [3:0]  n_in_tag, n_out_tag;
  logic [7:0]  n_out_s, n_out_t, n_out_sum;

  csa_tree_pipe #(.W(8), .N(2), .REG_EVERY(1), .TAG_W(4)) u_dut_n2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .in_partials(n_in_partials),
    .in_tag     (n_in_tag),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_s      (n_out_s),
    .out_t      (n_out_t),
    .out_sum    (n_out_sum),
    .out_tag    (n_out_tag)
  );

  // Default config: W=116, N=58, REG_EVERY=2 -> LAT=3
  logic             d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [DN*DW-1:0] d_in_partials;
  logic [3:0]       d_in_tag, d_out_tag;
  logic [DW-1:0]    d_out_s, d_out_t, d_out_sum;

  csa_tree_pipe u_dut_dflt (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (d_in_valid),
    .in_ready   (d_in_ready),
    .in_partials(d_in_partials),
    .in_tag     (d_in_tag),
    .out_valid  (d_out_valid),
    .out_ready  (d_out_ready),
    .out_s      (d_out_s),
    .out_t      (d_out_t),
    .out_sum    (d_out_sum),
    .out_tag    (d_out_tag)
  );

  // Scoreboard for the default instance; adv_at counts advancing cycles so the
  // latency check stays exact across stalls.
  typedef struct packed {
    logic [DW-1:0] sum;
    logic [3:0]    tag;
    int unsigned   adv_at;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned adv_cnt = 0;

  initial begin : mon
    logic [DW-1:0] ref_sum;
    logic [DW-1:0] st;
    sb_t           e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
      end else begin
        if (d_out_valid) begin
          if (sb_q.size() == 0) begin
            check("d_stray_out", d_out_valid, 1'b0);
          end else begin
            st = d_out_s + d_out_t;
            check("d_sum", d_out_sum, sb_q[0].sum);
            check("d_s_plus_t", st, sb_q[0].sum);
            check("d_t0", d_out_t[0], 1'b0);
            check("d_tag", d_out_tag, sb_q[0].tag);
            check("d_latency", adv_cnt - sb_q[0].adv_at, DLAT);
            if (d_out_ready) void'(sb_q.pop_front());
          end
        end
        if (d_in_valid && d_in_ready) begin
          ref_sum = '0;
          for (int i = 0; i < DN; i++) ref_sum += d_in_partials[i*DW +: DW];
          e.sum    = ref_sum;
          e.tag    = d_in_tag;
          e.adv_at = adv_cnt;
          sb_q.push_back(e);
        end
        if (d_in_ready) adv_cnt++;
      end
    end
  end

  task automatic send_dflt(input logic [3:0] tag);
    logic [127:0] r;
    bit           done;
    done = 1'b0;
    for (int i = 0; i < DN; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      d_in_partials[i*DW +: DW] = r[DW-1:0];
    end
    d_in_tag   = tag;
    d_in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (d_in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("d_accept_timeout", d_in_ready, 1'b1);
    d_in_valid = 1'b0;
  endtask

  task automatic stall4();
    logic [DW-1:0] fs, ft;
    logic [3:0]    ftag;
    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_in_ready", d_in_ready, 1'b0);
      if (k == 0) begin
        check("stall_valid", d_out_valid, 1'b1);
        fs   = d_out_s;
        ft   = d_out_t;
        ftag = d_out_tag;
      end else begin
        check("stall_s", d_out_s, fs);
        check("stall_t", d_out_t, ft);
        check("stall_tag", d_out_tag, ftag);
      end
    end
    @(posedge clk);
    #1;
    d_out_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] st8;
    rst           = 1'b1;
    s_in_valid    = 1'b0; s_in_partials = '0; s_in_tag = '0; s_out_ready = 1'b1;
    n_in_valid    = 1'b0; n_in_partials = '0; n_in_tag = '0; n_out_ready = 1'b1;
    d_in_valid    = 1'b0; d_in_partials = '0; d_in_tag = '0; d_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_s_valid", s_out_valid, 1'b0);
    check("rst_s_sum", s_out_sum, 8'd0);
    check("rst_s_ready", s_in_ready, 1'b1);
    check("rst_d_valid", d_out_valid, 1'b0);
    check("rst_d_s", d_out_s, '0);
    check("rst_d_t", d_out_t, '0);
    check("rst_d_sum", d_out_sum, '0);
    check("rst_d_tag", d_out_tag, 4'd0);
    check("rst_d_ready", d_in_ready, 1'b1);
    check("rst_n_valid", n_out_valid, 1'b0);

    // Small: {1,2,3,4,5}, tag 3
    s_in_partials = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    s_in_tag      = 4'd3;
    s_in_valid    = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    check("small_lat1_valid", s_out_valid, 1'b0);
    @(posedge clk);
    #1;
    st8 = s_out_s + s_out_t;
    check("small_valid", s_out_valid, 1'b1);
    check("small_sum", s_out_sum, 8'd15);
    check("small_s_plus_t", st8, 8'd15);
    check("small_t0", s_out_t[0], 1'b0);
    check("small_tag", s_out_tag, 4'd3);

    // Small: all 0xFF, carries past bit 7 dropped
    s_in_partials = '1;
    s_in_tag      = 4'd9;
    s_in_valid    = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    check("small_bubble_valid", s_out_valid, 1'b0);
    @(posedge clk);
    #1;
    st8 = s_out_s + s_out_t;
    check("ff_valid", s_out_valid, 1'b1);
    check("ff_sum", s_out_sum, 8'hFB);
    check("ff_s_plus_t", st8, 8'hFB);
    check("ff_tag", s_out_tag, 4'd9);

    // N=2: {0,0} then {7,9}
    n_in_partials = 16'h0000;
    n_in_tag      = 4'd1;
    n_in_valid    = 1'b1;
    @(posedge clk);
    #1;
    n_in_partials = {8'd9, 8'd7};
    n_in_tag      = 4'd2;
    check("n2_zero_valid", n_out_valid, 1'b1);
    check("n2_zero_sum", n_out_sum, 8'd0);
    check("n2_zero_t", n_out_t, 8'd0);
    check("n2_zero_tag", n_out_tag, 4'd1);
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    check("n2_79_valid", n_out_valid, 1'b1);
    check("n2_79_sum", n_out_sum, 8'd16);
    check("n2_79_t0", n_out_t[0], 1'b0);
    check("n2_79_tag", n_out_tag, 4'd2);

    // Default: 200 back-to-back random sets with a 4-cycle output stall
    fork
      for (int i = 0; i < 200; i++) send_dflt(4'(i));
      begin
        repeat (60) @(posedge clk);
        stall4();
      end
    join
    repeat (DLAT + 3) @(posedge clk);
    #1;
    check("d_drain", sb_q.size(), 0);

    // Reset with two sets in flight
    send_dflt(4'hA);
    send_dflt(4'hB);
    check("inflight_no_out", d_out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", d_out_valid, 1'b0);
    check("mid_rst_s", d_out_s, '0);
    check("mid_rst_t", d_out_t, '0);
    check("mid_rst_sum", d_out_sum, '0);
    check("mid_rst_tag", d_out_tag, 4'd0);
    check("mid_rst_ready", d_in_ready, 1'b1);
    send_dflt(4'hC);
    repeat (DLAT + 3) @(posedge clk);
    #1;
    check("post_rst_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
